// File: rtl/sdio_dev_cmd_if.sv
// sdio_dev_cmd_if: device-logic side of the SDIO card CMD engine (decoded command out, response request in)
interface sdio_dev_cmd_if;
  logic         cmd_valid;
  logic [5:0]   cmd_op;
  logic [31:0]  cmd_arg;
  logic         cmd_crc_err;
  logic         cmd_end_err;
  logic         rsp_start;
  logic [2:0]   rsp_type;
  logic [127:0] rsp_data;
  logic         rsp_busy;
  logic         rsp_done;
  logic         rsp_drop;
  modport slave (
    output cmd_valid, cmd_op, cmd_arg, cmd_crc_err, cmd_end_err, rsp_busy, rsp_done, rsp_drop,
    input  rsp_start, rsp_type, rsp_data
  );
  modport master (
    input  cmd_valid, cmd_op, cmd_arg, cmd_crc_err, cmd_end_err, rsp_busy, rsp_done, rsp_drop,
    output rsp_start, rsp_type, rsp_data
  );
endinterface

// File: rtl/sdio_dev_cmd.sv
// sdio_dev_cmd: card-side SDIO CMD line engine, receives 48-bit host commands and serialises responses
module sdio_dev_cmd #(
  parameter int NCR_MIN     = 2,
  parameter int RSP_TIMEOUT = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          sdcmd_i,
  output logic          sdcmd_o,
  output logic          sdcmd_oen_o,
  sdio_dev_cmd_if.slave bus
);
  typedef enum logic [3:0] {
    ST_IDLE, ST_RX_DIR, ST_RX_SHIFT, ST_RX_CRC, ST_RX_STOP, ST_CMD_OUT, ST_WAIT_RSP,
    ST_TX_GAP, ST_TX_START, ST_TX_DIR, ST_TX_SHIFT, ST_TX_CRC, ST_TX_STOP
  } state_t;
  state_t       state, state_nxt;
  logic [7:0]   cnt, cnt_nxt;
  logic [6:0]   crc;
  logic [37:0]  rx_sr;
  logic [132:0] tx_sr;
  logic [2:0]   rsp_type_q;
  logic         crc_bad, accept, drop, drop_q, tx_en, tx_bit, cnt_zero, is136;
  function automatic logic [6:0] crc7(input logic [6:0] c, input logic b);
    return {c[5:0], 1'b0} ^ ({7{c[6] ^ b}} & 7'h09);
  endfunction
  assign cnt_zero        = cnt == 8'd0;
  assign is136           = rsp_type_q == 3'b011;
  assign tx_en           = state inside {ST_TX_START, ST_TX_DIR, ST_TX_SHIFT, ST_TX_CRC, ST_TX_STOP};
  assign tx_bit          = state == ST_TX_SHIFT ? tx_sr[132] :
                           state == ST_TX_CRC   ? (rsp_type_q == 3'b010 || crc[6]) :
                           !(state inside {ST_TX_START, ST_TX_DIR});
  assign bus.cmd_valid   = state == ST_CMD_OUT;
  assign bus.rsp_busy    = state inside {ST_TX_GAP, ST_TX_START, ST_TX_DIR, ST_TX_SHIFT, ST_TX_CRC, ST_TX_STOP};
  assign bus.rsp_done    = state == ST_TX_STOP;
  assign bus.rsp_drop    = drop_q;
  // next state and shared down-counter; the counter loads target-1 and a phase ends at 0
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt - 8'd1;
    accept    = 1'b0;
    drop      = 1'b0;
    case (state)
      ST_IDLE:     state_nxt = sdcmd_i ? ST_IDLE : ST_RX_DIR;
      ST_RX_DIR: begin
        state_nxt = sdcmd_i ? ST_RX_SHIFT : ST_IDLE;
        cnt_nxt   = 8'd37;
      end
      ST_RX_SHIFT: if (cnt_zero) begin
        state_nxt = ST_RX_CRC;
        cnt_nxt   = 8'd6;
      end
      ST_RX_CRC:   state_nxt = cnt_zero ? ST_RX_STOP : ST_RX_CRC;
      ST_RX_STOP: begin
        state_nxt = ST_CMD_OUT;
        cnt_nxt   = 8'(RSP_TIMEOUT - 1);
      end
      ST_CMD_OUT, ST_WAIT_RSP: begin
        state_nxt = ST_WAIT_RSP;
        if (!sdcmd_i) begin
          drop      = 1'b1;
          state_nxt = ST_RX_DIR;
        end else if (bus.rsp_start) begin
          accept    = bus.rsp_type != 3'b000;
          state_nxt = accept ? ST_TX_GAP : ST_IDLE;
          cnt_nxt   = 8'(NCR_MIN - 1);
        end else if (cnt_zero) begin
          drop      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_TX_GAP:   state_nxt = cnt_zero ? ST_TX_START : ST_TX_GAP;
      ST_TX_START: state_nxt = ST_TX_DIR;
      ST_TX_DIR: begin
        state_nxt = ST_TX_SHIFT;
        cnt_nxt   = is136 ? 8'd132 : 8'd37;
      end
      ST_TX_SHIFT: if (cnt_zero) begin
        state_nxt = is136 ? ST_TX_STOP : ST_TX_CRC;
        cnt_nxt   = 8'd6;
      end
      ST_TX_CRC:   state_nxt = cnt_zero ? ST_TX_STOP : ST_TX_CRC;
      ST_TX_STOP:  state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end
  // state, counter and registered drop pulse
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      drop_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      drop_q <= drop;
    end
  // CRC7 shared by RX and TX: cleared at the start bit, covers direction through last content bit
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) crc <= '0;
    else if (state == ST_RX_DIR) crc <= crc7(7'd0, sdcmd_i);
    else if (state == ST_RX_SHIFT) crc <= crc7(crc, sdcmd_i);
    else if (state == ST_TX_START) crc <= '0;
    else if (state inside {ST_TX_DIR, ST_TX_SHIFT}) crc <= crc7(crc, tx_bit);
    else if (state inside {ST_RX_CRC, ST_TX_CRC}) crc <= {crc[5:0], 1'b0};
  // command deserialiser and outputs that only change when cmd_valid is raised
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rx_sr           <= '0;
      crc_bad         <= 1'b0;
      bus.cmd_op      <= '0;
      bus.cmd_arg     <= '0;
      bus.cmd_crc_err <= 1'b0;
      bus.cmd_end_err <= 1'b0;
    end else begin
      if (state == ST_RX_SHIFT) rx_sr <= {rx_sr[36:0], sdcmd_i};
      crc_bad <= state == ST_RX_DIR ? 1'b0 : crc_bad | (state == ST_RX_CRC && sdcmd_i != crc[6]);
      if (state == ST_RX_STOP) begin
        bus.cmd_op      <= rx_sr[37:32];
        bus.cmd_arg     <= rx_sr[31:0];
        bus.cmd_crc_err <= crc_bad;
        bus.cmd_end_err <= !sdcmd_i;
      end
    end
  // response latch on acceptance; the 136-bit form prefixes the reserved 111111 field
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rsp_type_q <= '0;
      tx_sr      <= '0;
    end else if (accept) begin
      rsp_type_q <= bus.rsp_type;
      tx_sr      <= bus.rsp_type == 3'b011 ? {6'h3f, bus.rsp_data[127:1]} : {bus.rsp_data[37:0], 95'd0};
    end else if (state == ST_TX_SHIFT) tx_sr <= tx_sr << 1;
  // CMD line driven from negedge flops so the host samples a settled bit on posedge
  always_ff @(negedge clk_i or posedge rst_i)
    if (rst_i) begin
      sdcmd_o     <= 1'b1;
      sdcmd_oen_o <= 1'b1;
    end else begin
      sdcmd_o     <= tx_bit;
      sdcmd_oen_o <= !tx_en;
    end
endmodule

// File: tb/tb_sdio_dev_cmd.sv
// tb_sdio_dev_cmd: scoreboard bench for the SDIO card CMD engine
module tb_sdio_dev_cmd;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic sdcmd_i = 1'b1;
  logic sdcmd_o, sdcmd_oen_o;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int drop_cnt = 0;
  int nbits = 0;
  logic [135:0] cap;
  typedef struct { logic [5:0] op; logic [31:0] arg; logic ce; logic ee; } cmd_t;
  typedef struct { logic [135:0] bits; int len; } rsp_t;
  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];
  localparam logic [47:0] CMD0     = 48'h40_0000_0000_95;
  localparam logic [47:0] CMD8     = 48'h48_0000_01AA_87;
  localparam logic [47:0] CMD0_BCRC = 48'h40_0000_0000_97;
  localparam logic [47:0] CMD0_BEND = 48'h40_0000_0000_94;
  localparam logic [47:0] FOREIGN  = 48'h3F_FFFF_FFFF_FF;
  localparam logic [127:0] A5      = {16{8'hA5}};
  sdio_dev_cmd_if bus();
  sdio_dev_cmd dut (
    .clk_i(clk_i), .rst_i(rst_i), .sdcmd_i(sdcmd_i),
    .sdcmd_o(sdcmd_o), .sdcmd_oen_o(sdcmd_oen_o), .bus(bus)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic push_cmd(input logic [5:0] op, input logic [31:0] arg, input logic ce, input logic ee);
    cmd_t c;
    c.op = op; c.arg = arg; c.ce = ce; c.ee = ee;
    exp_cmd.push_back(c);
  endtask
  task automatic push_rsp(input logic [135:0] bits, input int len);
    rsp_t r;
    r.bits = bits; r.len = len;
    exp_rsp.push_back(r);
  endtask
  task automatic send(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge clk_i);
      sdcmd_i = f[i];
    end
    @(negedge clk_i);
    sdcmd_i = 1'b1;
  endtask
  task automatic wait_valid();
    int k;
    for (k = 0; k < 100 && !bus.cmd_valid; k++) @(negedge clk_i);
    if (k >= 100) begin
      checks++; failures++;
      $display("FAIL valid_timeout actual=no cmd_valid required=cmd_valid");
    end
  endtask
  task automatic respond(input logic [2:0] t, input logic [127:0] d);
    bus.rsp_type = t;
    bus.rsp_data = d;
    bus.rsp_start = 1'b1;
    @(posedge clk_i);
    #1 bus.rsp_start = 1'b0;
  endtask
  task automatic wait_tx();
    int k;
    for (k = 0; k < 400 && bus.rsp_busy; k++) @(negedge clk_i);
    if (k >= 400) begin
      checks++; failures++;
      $display("FAIL tx_timeout actual=busy required=idle");
    end
    repeat (2) @(negedge clk_i);
  endtask
  // command scoreboard: pops the expected command whenever cmd_valid is seen
  initial forever begin
    @(negedge clk_i);
    if (bus.rsp_done) done_cnt++;
    if (bus.rsp_drop) drop_cnt++;
    if (!rst_i && bus.cmd_valid) begin
      if (exp_cmd.size() == 0) begin
        checks++; failures++;
        $display("FAIL cmd_unexpected actual=op %0h required=none", bus.cmd_op);
      end else begin
        cmd_t e;
        e = exp_cmd.pop_front();
        chk("cmd_op", 136'(bus.cmd_op), 136'(e.op));
        chk("cmd_arg", 136'(bus.cmd_arg), 136'(e.arg));
        chk("cmd_crc_err", 136'(bus.cmd_crc_err), 136'(e.ce));
        chk("cmd_end_err", 136'(bus.cmd_end_err), 136'(e.ee));
      end
    end
  end
  // line monitor: collects driven bits as the host would and checks each finished response
  initial forever begin
    @(posedge clk_i);
    if (rst_i) nbits = 0;
    else if (!sdcmd_oen_o) begin
      cap = (nbits == 0 ? 136'd0 : cap << 1) | 136'(sdcmd_o);
      nbits++;
    end else if (nbits > 0) begin
      if (exp_rsp.size() == 0) begin
        checks++; failures++;
        $display("FAIL rsp_unexpected actual=%0d bits required=none", nbits);
      end else begin
        rsp_t e;
        e = exp_rsp.pop_front();
        chk("rsp_len", 136'(nbits), 136'(e.len));
        chk("rsp_bits", cap, e.bits);
      end
      nbits = 0;
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
  initial begin
    int k, d0;
    bus.rsp_start = 1'b0;
    bus.rsp_type = 3'b000;
    bus.rsp_data = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_oen", 136'(sdcmd_oen_o), 136'(1));
    chk("rst_cmd_o", 136'(sdcmd_o), 136'(1));
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_valid", 136'(bus.cmd_valid), 136'(0));
    chk("rst_op_arg", 136'({bus.cmd_op, bus.cmd_arg}), 136'(0));
    chk("rst_errs", 136'({bus.cmd_crc_err, bus.cmd_end_err}), 136'(0));
    chk("rst_pulses", 136'({bus.rsp_busy, bus.rsp_done, bus.rsp_drop}), 136'(0));
    // CMD0, no response
    push_cmd(6'd0, 32'd0, 1'b0, 1'b0);
    send(CMD0); wait_valid(); respond(3'b000, '0);
    // CMD8 with R7, gap measured from acceptance to start bit seen by host
    push_cmd(6'd8, 32'h1AA, 1'b0, 1'b0);
    push_rsp(136'h08_0000_01AA_13, 48);
    send(CMD8); wait_valid();
    d0 = done_cnt;
    respond(3'b001, 128'h8_0000_01AA);
    chk("busy_on_accept", 136'(bus.rsp_busy), 136'(1));
    for (k = 0; k < 20 && sdcmd_oen_o; k++) @(posedge clk_i);
    chk("ncr_gap", 136'(k), 136'(3));
    wait_tx();
    chk("done_pulses", 136'(done_cnt - d0), 136'(1));
    chk("oen_released", 136'(sdcmd_oen_o), 136'(1));
    chk("op_hold", 136'(bus.cmd_op), 136'(8));
    // CRC and end-bit errors still reported
    push_cmd(6'd0, 32'd0, 1'b1, 1'b0);
    send(CMD0_BCRC); wait_valid(); respond(3'b000, '0);
    push_cmd(6'd0, 32'd0, 1'b0, 1'b1);
    send(CMD0_BEND); wait_valid(); respond(3'b000, '0);
    // frame from another device ignored, following command decoded
    send(FOREIGN);
    push_cmd(6'd0, 32'd0, 1'b0, 1'b0);
    send(CMD0); wait_valid(); respond(3'b000, '0);
    // 136-bit response
    push_cmd(6'd0, 32'd0, 1'b0, 1'b0);
    push_rsp({8'h3F, A5}, 136);
    send(CMD0); wait_valid(); respond(3'b011, A5); wait_tx();
    // 48-bit without CRC: CRC field all ones
    push_cmd(6'd0, 32'd0, 1'b0, 1'b0);
    push_rsp(136'h03_1234_0000_FF, 48);
    send(CMD0); wait_valid(); respond(3'b010, 128'h3_1234_0000); wait_tx();
    // busy type framed like 001
    push_cmd(6'd8, 32'h1AA, 1'b0, 1'b0);
    push_rsp(136'h08_0000_01AA_13, 48);
    send(CMD8); wait_valid(); respond(3'b100, 128'h8_0000_01AA); wait_tx();
    // response timeout
    push_cmd(6'd0, 32'd0, 1'b0, 1'b0);
    d0 = drop_cnt;
    send(CMD0); wait_valid();
    for (k = 0; k < 200 && !bus.rsp_drop; k++) @(negedge clk_i);
    chk("timeout_cycles", 136'(k), 136'(64));
    repeat (2) @(negedge clk_i);
    chk("timeout_drops", 136'(drop_cnt - d0), 136'(1));
    // new host command while waiting drops the pending response
    push_cmd(6'd0, 32'd0, 1'b0, 1'b0);
    send(CMD0); wait_valid();
    repeat (4) @(negedge clk_i);
    d0 = drop_cnt;
    push_cmd(6'd8, 32'h1AA, 1'b0, 1'b0);
    send(CMD8); wait_valid();
    chk("newcmd_drops", 136'(drop_cnt - d0), 136'(1));
    respond(3'b000, '0);
    repeat (2) @(negedge clk_i);
    chk("none_not_busy", 136'(bus.rsp_busy), 136'(0));
    // reset in the middle of a 136-bit response
    push_cmd(6'd0, 32'd0, 1'b0, 1'b0);
    send(CMD0); wait_valid(); respond(3'b011, A5);
    for (k = 0; k < 20 && sdcmd_oen_o; k++) @(posedge clk_i);
    repeat (10) @(posedge clk_i);
    chk("mid_rsp_driving", 136'(sdcmd_oen_o), 136'(0));
    #2 rst_i = 1'b1;
    #1 chk("mid_rst_oen", 136'(sdcmd_oen_o), 136'(1));
    chk("mid_rst_cmd_o", 136'(sdcmd_o), 136'(1));
    chk("mid_rst_busy", 136'(bus.rsp_busy), 136'(0));
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    push_cmd(6'd8, 32'h1AA, 1'b0, 1'b0);
    send(CMD8); wait_valid(); respond(3'b000, '0);
    repeat (5) @(negedge clk_i);
    chk("cmd_q_empty", 136'(exp_cmd.size()), 136'(0));
    chk("rsp_q_empty", 136'(exp_rsp.size()), 136'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
